// File: rtl/lsu_bus_master.sv
// Load/store bus master: turns pipeline byte/half/word/double accesses into
// doubleword bus cycles, with read-modify-write for partial memory stores.
module lsu_bus_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [63:0] direccion,
    output logic [63:0] dataWrite,
    output logic        memWr,
    input  logic [63:0] dataRead
);
    // state | meaning
    // IDLE  | waiting for a request, req_ready=1
    // RD    | bus read of the addressed doubleword
    // WR    | one-cycle bus write strobe
    // RESP  | response held until resp_ready
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [15:0] addr_q;
    logic [63:0] wdata_q, word_q, rdata_q;
    logic        accept, req_err, sign_bit;
    logic [2:0]  align;
    logic [5:0]  sh;
    logic [63:0] mask, shifted, load_val, store_val;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        case (req_size)
            2'd0:    align = 3'b000;
            2'd1:    align = 3'b001;
            2'd2:    align = 3'b011;
            default: align = 3'b111;
        endcase
    end

    assign req_err = (|(req_addr[2:0] & align)) || (|req_addr[63:16])
                     || (req_addr[15] && (req_addr[2:0] != 3'd0));

    assign sh = {addr_q[2:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    always_comb begin
        shifted = (dataRead >> sh) & mask;
        case (size_q)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[63];
        endcase
        load_val = (sgn_q && sign_bit) ? (shifted | ~mask) : shifted;
    end

    // Partial memory stores merge into the word captured in RD; IO and
    // doubleword stores go out as the zero-extended store data.
    always_comb begin
        if (!addr_q[15] && (size_q != 2'd3))
            store_val = (word_q & ~(mask << sh)) | ((wdata_q & mask) << sh);
        else
            store_val = wdata_q & mask;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (req_we && ((req_size == 2'd3) || req_addr[15]))
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 16'd0;
            wdata_q <= 64'd0;
            word_q  <= 64'd0;
            rdata_q <= 64'd0;
        end else if (accept) begin
            we_q    <= req_we;
            sgn_q   <= req_signed;
            err_q   <= req_err;
            size_q  <= req_size;
            addr_q  <= req_addr[15:0];
            wdata_q <= req_wdata;
            rdata_q <= 64'd0;
        end else if (state == RD) begin
            word_q <= dataRead;
            if (!we_q)
                rdata_q <= load_val;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_data  = (state == RESP) ? rdata_q : 64'd0;
    assign resp_err   = (state == RESP) && err_q;
    assign direccion  = (state == IDLE) ? 64'd0 : {51'd0, addr_q[15:3]};
    assign memWr      = (state == WR);
    assign dataWrite  = (state == WR) ? store_val : 64'd0;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: doubleword-array responder on the bus side and a
// byte-addressed reference memory that predicts every response.
module tb_lsu_bus_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err, memWr;
    logic [63:0] resp_data, direccion, dataWrite, dataRead;

    logic [63:0] bus_mem [0:8191];
    logic [7:0]  ref_mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    // model outputs
    logic        e_err;
    int          e_lat, e_nwr;
    logic [63:0] e_dw, e_data, e_dir;
    // observations
    int          o_lat, o_nwr;
    logic        o_err, o_dir_ok, o_hold_ok, o_idle_rdy;
    logic [63:0] o_data, o_dw, o_dir, o_wdir, o_idle_dir;

    lsu_bus_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .direccion(direccion), .dataWrite(dataWrite), .memWr(memWr),
        .dataRead(dataRead)
    );

    always #5 clk = ~clk;

    assign dataRead = bus_mem[direccion[12:0]];
    always @(posedge clk) if (memWr) bus_mem[direccion[12:0]] <= dataWrite;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: byte memory, little-endian, IO stores replace the whole doubleword.
    task automatic model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wd);
        int nb, off, base;
        logic [63:0] v;
        nb    = 1 << size;
        off   = int'(addr % 64'd8);
        base  = int'(addr[15:0]) - off;
        e_err = ((off % nb) != 0) || ((addr >> 16) != 64'd0) || (addr[15] && off != 0);
        e_dir = addr >> 3;
        e_nwr = 0; e_dw = 0; e_data = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            v = 0;
            for (int i = 0; i < nb; i++) v |= 64'(ref_mem[base + off + i]) << (8 * i);
            if (sgn && nb < 8 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1)
                v = v - (64'd1 << (8 * nb));
            e_data = v;
        end else begin
            e_nwr = 1;
            if (addr[15]) begin
                e_lat = 2;
                for (int i = 0; i < 8; i++) ref_mem[base + i] = (i < nb) ? wd[8*i +: 8] : 8'd0;
            end else begin
                e_lat = (nb == 8) ? 2 : 3;
                for (int i = 0; i < nb; i++) ref_mem[base + off + i] = wd[8*i +: 8];
            end
            for (int i = 0; i < 8; i++) e_dw |= 64'(ref_mem[base + i]) << (8 * i);
        end
    endtask

    task automatic run_req(input logic we, input logic [63:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [63:0] wd, input int stall, input bit finish);
        bit first;
        model(we, addr, size, sgn, wd);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_addr = {$urandom, $urandom};
        req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = {$urandom, $urandom};
        o_lat = 0; o_nwr = 0; o_dw = 0; o_wdir = 0; o_dir = 0; o_dir_ok = 1; first = 1;
        while (1) begin
            @(negedge clk);
            o_lat++;
            if (first) begin o_dir = direccion; first = 0; end
            else if (!resp_valid && direccion !== o_dir) o_dir_ok = 0;
            if (memWr) begin o_nwr++; o_dw = dataWrite; o_wdir = direccion; end
            if (resp_valid || o_lat >= 8) break;
        end
        o_data = resp_data; o_err = resp_err; o_hold_ok = 1;
        repeat (stall) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== o_data || resp_err !== o_err
                || req_ready !== 1'b0 || memWr !== 1'b0) o_hold_ok = 0;
        end
        if (finish) begin
            resp_ready = 1;
            @(posedge clk); #1;
            resp_ready = 0;
            @(negedge clk);
            o_idle_dir = direccion; o_idle_rdy = req_ready;
        end
    endtask

    task automatic test_reset;
        rst_n = 0; req_valid = 1; req_we = 1; req_addr = 64'h18; req_size = 2'd3;
        req_signed = 0; req_wdata = 64'hDEAD; resp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_err !== 1'b0
            || direccion !== 64'd0 || dataWrite !== 64'd0 || memWr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b dir=%h dw=%h wr=%b expected 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_data, resp_err, direccion, dataWrite, memWr);
        end
        req_valid = 0; rst_n = 1;
        @(negedge clk);
    endtask

    task automatic fill_memory;
        for (int i = 0; i < 32; i++) run_req(1, 64'(i * 8), 2'd3, 0, {$urandom, $urandom}, 0, 1);
        for (int i = 0; i < 32; i++) run_req(1, 64'h8000 + 64'(i * 8), 2'd3, 0, {$urandom, $urandom}, 0, 1);
    endtask

    task automatic test_dword;
        run_req(1, 64'h18, 2'd3, 0, 64'h1122334455667788, 0, 1);
        n_cmp++;
        if (o_nwr !== 1 || o_wdir !== 64'd3 || o_dw !== 64'h1122334455667788 || o_lat !== 2) begin
            n_err++;
            $display("FAIL dword_store: nwr=%0d dir=%h dw=%h lat=%0d expected 1 3 1122334455667788 2",
                     o_nwr, o_wdir, o_dw, o_lat);
        end
        run_req(0, 64'h18, 2'd3, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'h1122334455667788 || o_lat !== 2 || o_nwr !== 0) begin
            n_err++;
            $display("FAIL dword_load: data=%h lat=%0d nwr=%0d expected 1122334455667788 2 0",
                     o_data, o_lat, o_nwr);
        end
    endtask

    task automatic test_rmw;
        run_req(1, 64'h1A, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 1);
        n_cmp++;
        if (o_dw !== 64'h1122334455AB7788 || o_lat !== 3 || o_nwr !== 1 || o_wdir !== 64'd3) begin
            n_err++;
            $display("FAIL byte_rmw: dw=%h lat=%0d nwr=%0d dir=%h expected 1122334455AB7788 3 1 3",
                     o_dw, o_lat, o_nwr, o_wdir);
        end
        run_req(0, 64'h18, 2'd3, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'h1122334455AB7788) begin
            n_err++;
            $display("FAIL rmw_readback: got %h expected 1122334455AB7788", o_data);
        end
    endtask

    task automatic test_sign;
        run_req(1, 64'h0, 2'd3, 0, 64'h00000000000080F0, 0, 1);
        run_req(0, 64'h0, 2'd1, 1, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'hFFFFFFFFFFFF80F0) begin
            n_err++;
            $display("FAIL half_signed: got %h expected FFFFFFFFFFFF80F0", o_data);
        end
        run_req(0, 64'h0, 2'd1, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'h00000000000080F0) begin
            n_err++;
            $display("FAIL half_unsigned: got %h expected 00000000000080F0", o_data);
        end
    endtask

    task automatic test_errors;
        run_req(0, 64'h6, 2'd2, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_err !== 1'b1 || o_lat !== 1 || o_nwr !== 0 || o_data !== 64'd0) begin
            n_err++;
            $display("FAIL misaligned_load: err=%b lat=%0d nwr=%0d data=%h expected 1 1 0 0",
                     o_err, o_lat, o_nwr, o_data);
        end
        run_req(1, 64'h8001, 2'd0, 0, 64'h55, 0, 1);
        n_cmp++;
        if (o_err !== 1'b1 || o_nwr !== 0 || o_lat !== 1) begin
            n_err++;
            $display("FAIL io_offset_store: err=%b nwr=%0d lat=%0d expected 1 0 1", o_err, o_nwr, o_lat);
        end
        run_req(1, 64'h1_0000_0010, 2'd3, 0, 64'h77, 0, 1);
        n_cmp++;
        if (o_err !== 1'b1 || o_nwr !== 0) begin
            n_err++;
            $display("FAIL high_addr_store: err=%b nwr=%0d expected 1 0", o_err, o_nwr);
        end
    endtask

    task automatic test_io;
        run_req(1, 64'h8000, 2'd3, 0, 64'h00000000000000A5, 0, 1);
        run_req(0, 64'h8000, 2'd3, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'hA5 || o_lat !== 2 || o_err !== 1'b0) begin
            n_err++;
            $display("FAIL io_load: data=%h lat=%0d err=%b expected a5 2 0", o_data, o_lat, o_err);
        end
        run_req(1, 64'h8000, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FF3C, 0, 1);
        n_cmp++;
        if (o_wdir !== 64'h1000 || o_dw !== 64'h3C || o_lat !== 2 || o_nwr !== 1) begin
            n_err++;
            $display("FAIL io_store: dir=%h dw=%h lat=%0d nwr=%0d expected 1000 3c 2 1",
                     o_wdir, o_dw, o_lat, o_nwr);
        end
    endtask

    task automatic test_stall_reset;
        run_req(0, 64'h18, 2'd3, 0, 64'd0, 5, 0);
        n_cmp++;
        if (o_hold_ok !== 1'b1 || o_data !== e_data) begin
            n_err++;
            $display("FAIL resp_stall: hold_ok=%b data=%h expected 1 %h", o_hold_ok, o_data, e_data);
        end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_in_resp: vld=%b rdy=%b data=%h expected 0 1 0", resp_valid, req_ready, resp_data);
        end
    endtask

    task automatic test_reset_in_wr;
        logic quiet;
        model(1, 64'h20, 2'd3, 0, 64'hCAFE_F00D_1234_5678);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 64'h20; req_size = 2'd3;
        req_signed = 0; req_wdata = 64'hCAFE_F00D_1234_5678;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (memWr !== 1'b1) begin
            n_err++;
            $display("FAIL wr_before_reset: memWr=%b expected 1", memWr);
        end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (memWr !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_wr_quiet: got %b expected 1", quiet);
        end
        run_req(0, 64'h20, 2'd3, 0, 64'd0, 0, 1);
        n_cmp++;
        if (o_data !== 64'hCAFE_F00D_1234_5678) begin
            n_err++;
            $display("FAIL reset_in_wr_data: got %h expected cafef00d12345678", o_data);
        end
    endtask

    task automatic test_random;
        logic        we, sgn, io;
        logic [1:0]  size;
        logic [63:0] addr, wd;
        int          off;
        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom);
            sgn  = 1'($urandom);
            size = 2'($urandom);
            io   = ($urandom_range(0, 3) == 0);
            off  = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~((1 << size) - 1);
            if (io && $urandom_range(0, 9) < 7) off = 0;
            addr = (io ? 64'h8000 : 64'h0) + 64'($urandom_range(0, 31) * 8) + 64'(off);
            if ($urandom_range(0, 15) == 0) addr = addr | (64'h1_0000 << $urandom_range(0, 47));
            wd = {$urandom, $urandom};
            run_req(we, addr, size, sgn, wd, $urandom_range(0, 2), 1);
            n_cmp++;
            if (o_err !== e_err || o_lat !== e_lat || o_nwr !== e_nwr || o_data !== e_data) begin
                n_err++;
                $display("FAIL rand_resp[%0d] addr=%h we=%b sz=%0d: err=%b lat=%0d nwr=%0d data=%h expected %b %0d %0d %h",
                         n, addr, we, size, o_err, o_lat, o_nwr, o_data, e_err, e_lat, e_nwr, e_data);
            end
            if (!e_err) begin
                n_cmp++;
                if (o_dir !== e_dir || o_dir_ok !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_dir[%0d]: dir=%h stable=%b expected %h 1", n, o_dir, o_dir_ok, e_dir);
                end
            end
            if (e_nwr > 0) begin
                n_cmp++;
                if (o_dw !== e_dw || o_wdir !== e_dir) begin
                    n_err++;
                    $display("FAIL rand_wdata[%0d]: dw=%h dir=%h expected %h %h", n, o_dw, o_wdir, e_dw, e_dir);
                end
            end
            n_cmp++;
            if (o_idle_dir !== 64'd0 || o_idle_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL rand_idle[%0d]: dir=%h rdy=%b expected 0 1", n, o_idle_dir, o_idle_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_dword();
        test_rmw();
        test_sign();
        test_errors();
        test_io();
        test_stall_reset();
        test_reset_in_wr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
